// File: rtl/display_pkg.sv
// Shared encodings for the board display path: display modes and the blank codes.
package display_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC   = 2'd0,
        MODE_BLINK    = 2'd1,
        MODE_SCROLL   = 2'd2,
        MODE_GAMEOVER = 2'd3
    } mode_e;

    localparam logic [6:0] SEG_BLANK    = 7'h7F;
    localparam logic [3:0] NIBBLE_BLANK = 4'hF;

endpackage

// File: rtl/hex_7seg.sv
// Nibble to active-low seven-segment glyph (bit 0 = segment a); code F is blank.
module hex_7seg
    import display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Latches hex digits and an LED pattern, then drives the seven-segment and LED pins
// in static, blink, scroll or game-over flash mode. All pins are registered.
module hex_display_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int NUM_LEDS   = 10,
    parameter int BLINK_DIV  = 25000000,
    parameter int SCROLL_DIV = 12500000
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digit_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_LEDS-1:0]     led_in,
    input  logic [1:0]              mode,
    output logic [7*NUM_DIGITS-1:0] HEX_OUT,
    output logic [NUM_LEDS-1:0]     LEDR,
    output logic                    step_tick
);

    localparam int MAX_DIV = (BLINK_DIV > SCROLL_DIV) ? BLINK_DIV : SCROLL_DIV;
    localparam int CNT_W   = $clog2(MAX_DIV);
    localparam int OFF_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int LED_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_DIV - 1);
    localparam logic [CNT_W-1:0] SCROLL_LAST = CNT_W'(SCROLL_DIV - 1);
    localparam logic [OFF_W-1:0] OFF_LAST    = OFF_W'(NUM_DIGITS - 1);
    localparam logic [LED_W-1:0] LED_LAST    = LED_W'(NUM_LEDS - 1);

    logic [3:0]            dig_sh [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blank_sh;
    logic [NUM_LEDS-1:0]   led_sh;

    logic [CNT_W-1:0] cnt;
    logic             phase;
    logic [OFF_W-1:0] offset;
    logic [LED_W-1:0] led_idx;
    mode_e            mode_q;

    logic             clr;
    logic             wrap;
    logic [CNT_W-1:0] div_last;

    logic [3:0]            nib_sel_p0 [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blk_sel_p0;
    logic [6:0]            seg_raw_p0 [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0] hex_p0;
    logic [NUM_LEDS-1:0]     led_p0;

    // load and a mode change share one clear; the divider only wraps when nothing clears it
    assign clr      = load || (mode != mode_q);
    assign div_last = (mode_q == MODE_SCROLL) ? SCROLL_LAST : BLINK_LAST;
    assign wrap     = (mode_q != MODE_STATIC) && (cnt == div_last) && !clr;

    // stage p0: pick the source digit for each position, rotating in SCROLL
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            int src;
            src = k;
            if (mode_q == MODE_SCROLL) begin
                src = k + int'(offset);
                if (src >= NUM_DIGITS) src = src - NUM_DIGITS;
            end
            nib_sel_p0[k] = dig_sh[src];
            blk_sel_p0[k] = blank_sh[src];
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        hex_7seg u_dec (
            .hex (nib_sel_p0[g]),
            .seg (seg_raw_p0[g])
        );
    end

    always_comb begin
        hex_p0 = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!blk_sel_p0[k] && !(mode_q == MODE_BLINK && phase))
                hex_p0[7*k +: 7] = seg_raw_p0[k];
        end

        led_p0 = '0;
        case (mode_q)
            MODE_STATIC: led_p0 = led_sh;
            MODE_BLINK:  led_p0 = phase ? '0 : led_sh;
            MODE_SCROLL: begin
                for (int i = 0; i < NUM_LEDS; i++)
                    led_p0[i] = (led_idx == LED_W'(i));
            end
            default:     led_p0 = phase ? '0 : '1;
        endcase
    end

    // stage p1: shadow, divider and state updates plus the registered pins
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int k = 0; k < NUM_DIGITS; k++) dig_sh[k] <= NIBBLE_BLANK;
            blank_sh  <= '1;
            led_sh    <= '0;
            cnt       <= '0;
            phase     <= 1'b0;
            offset    <= '0;
            led_idx   <= '0;
            mode_q    <= MODE_STATIC;
            HEX_OUT   <= '1;
            LEDR      <= '0;
            step_tick <= 1'b0;
        end else begin
            mode_q    <= mode_e'(mode);
            HEX_OUT   <= hex_p0;
            LEDR      <= led_p0;
            step_tick <= wrap;

            if (load) begin
                for (int k = 0; k < NUM_DIGITS; k++) dig_sh[k] <= digit_in[4*k +: 4];
                blank_sh <= blank_in;
                led_sh   <= led_in;
            end

            if (clr) begin
                cnt     <= '0;
                phase   <= 1'b0;
                offset  <= '0;
                led_idx <= '0;
            end else if (mode_q == MODE_STATIC) begin
                cnt <= '0;
            end else if (wrap) begin
                cnt <= '0;
                if (mode_q == MODE_SCROLL) begin
                    // led_idx tracks offset mod NUM_LEDS and restarts whenever offset does
                    if (offset == OFF_LAST) begin
                        offset  <= '0;
                        led_idx <= '0;
                    end else begin
                        offset  <= offset + 1'b1;
                        led_idx <= (led_idx == LED_LAST) ? '0 : led_idx + 1'b1;
                    end
                end else begin
                    phase <= ~phase;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl with a per-cycle scoreboard of pin values.
module tb_hex_display_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] digit_in;
    logic [3:0]  blank_in;
    logic [9:0]  led_in;
    logic [1:0]  mode;
    logic [27:0] HEX_OUT;
    logic [9:0]  LEDR;
    logic        step_tick;

    always #5 clk = ~clk;

    hex_display_ctrl #(
        .NUM_DIGITS (4),
        .NUM_LEDS   (10),
        .BLINK_DIV  (4),
        .SCROLL_DIV (3)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .load      (load),
        .digit_in  (digit_in),
        .blank_in  (blank_in),
        .led_in    (led_in),
        .mode      (mode),
        .HEX_OUT   (HEX_OUT),
        .LEDR      (LEDR),
        .step_tick (step_tick)
    );

    typedef struct {
        logic [27:0] hex;
        logic [9:0]  led;
        logic        tick;
    } exp_t;

    exp_t sb[$];

    logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F};

    logic [3:0] m_dig [4];
    logic [3:0] m_blank;
    logic [9:0] m_led;
    int         m_cnt;
    logic       m_phase;
    int         m_off;
    logic [1:0] m_mode;

    int total = 0;
    int bad   = 0;
    int ticks = 0;

    logic [27:0] pat1234;
    logic [6:0]  d0_exp [5];
    logic [9:0]  led_walk [5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one clock edge, using the inputs present at that edge.
    task automatic model_edge(output exp_t e);
        int   div;
        logic clr;
        logic w;
        if (reset) begin
            e.hex = '1;
            e.led = '0;
            e.tick = 1'b0;
            for (int k = 0; k < 4; k++) m_dig[k] = 4'hF;
            m_blank = 4'hF;
            m_led   = '0;
            m_cnt   = 0;
            m_phase = 1'b0;
            m_off   = 0;
            m_mode  = 2'd0;
            return;
        end
        e.hex = '0;
        for (int k = 0; k < 4; k++) begin
            int         i;
            logic [6:0] s;
            i = (m_mode == 2'd2) ? (k + m_off) % 4 : k;
            s = m_blank[i] ? 7'h7F : segtab[m_dig[i]];
            if (m_mode == 2'd1 && m_phase) s = 7'h7F;
            e.hex[7*k +: 7] = s;
        end
        case (m_mode)
            2'd0:    e.led = m_led;
            2'd1:    e.led = m_phase ? 10'h000 : m_led;
            2'd2:    e.led = 10'b1 << (m_off % 10);
            default: e.led = m_phase ? 10'h000 : 10'h3FF;
        endcase
        clr = load || (mode != m_mode);
        div = (m_mode == 2'd2) ? 3 : 4;
        w   = (m_mode != 2'd0) && (m_cnt == div - 1) && !clr;
        e.tick = w;
        if (load) begin
            for (int k = 0; k < 4; k++) m_dig[k] = digit_in[4*k +: 4];
            m_blank = blank_in;
            m_led   = led_in;
        end
        if (clr) begin
            m_cnt = 0; m_phase = 1'b0; m_off = 0;
        end else if (m_mode == 2'd0) begin
            m_cnt = 0;
        end else if (w) begin
            m_cnt = 0;
            if (m_mode == 2'd2) m_off = (m_off + 1) % 4;
            else m_phase = ~m_phase;
        end else begin
            m_cnt++;
        end
        m_mode = mode;
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        model_edge(e);
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        check("sb_hex", 32'(HEX_OUT), 32'(e.hex));
        check("sb_led", 32'(LEDR), 32'(e.led));
        check("sb_tick", 32'(step_tick), 32'(e.tick));
        if (step_tick) ticks++;
    endtask

    initial begin
        pat1234 = {7'h79, 7'h24, 7'h30, 7'h19};
        d0_exp   = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h19};
        led_walk = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h001};

        reset = 1'b1; load = 1'b0; mode = 2'd0;
        digit_in = '0; blank_in = '0; led_in = '0;

        // reset held two cycles, then released without a load
        cyc(); cyc();
        check("rst_hex", 32'(HEX_OUT), 32'h0FFFFFFF);
        check("rst_led", 32'(LEDR), 32'h0);
        check("rst_tick", 32'(step_tick), 32'h0);
        reset = 1'b0;
        cyc(); cyc();
        check("rel_hex", 32'(HEX_OUT), 32'h0FFFFFFF);

        // static load with blank mask
        digit_in = 16'h12AF; blank_in = 4'b0100; led_in = 10'h155; load = 1'b1;
        cyc();
        load = 1'b0;
        cyc();
        check("static_hex", 32'(HEX_OUT), 32'({7'h79, 7'h7F, 7'h08, 7'h7F}));
        check("static_led", 32'(LEDR), 32'h155);
        ticks = 0;
        for (int i = 0; i < 20; i++) cyc();
        check("static_ticks", 32'(ticks), 32'h0);

        // blink: load coinciding with the mode change
        digit_in = 16'h1234; blank_in = 4'b0000; load = 1'b1; mode = 2'd1;
        cyc();
        load = 1'b0;
        ticks = 0;
        cyc();
        check("blink_on_hex", 32'(HEX_OUT), 32'(pat1234));
        check("blink_on_led", 32'(LEDR), 32'h155);
        cyc(); cyc(); cyc();
        cyc();
        check("blink_off_hex", 32'(HEX_OUT), 32'h0FFFFFFF);
        check("blink_off_led", 32'(LEDR), 32'h0);
        for (int i = 0; i < 11; i++) cyc();
        check("blink_ticks", 32'(ticks), 32'h4);

        // scroll: digit 0 rotates through the shadow, LED walks with the offset
        mode = 2'd2;
        cyc();
        cyc();
        check("scroll_d0_0", 32'(HEX_OUT[6:0]), 32'(d0_exp[0]));
        check("scroll_led_0", 32'(LEDR), 32'(led_walk[0]));
        for (int s = 1; s < 5; s++) begin
            cyc(); cyc(); cyc();
            check("scroll_d0", 32'(HEX_OUT[6:0]), 32'(d0_exp[s]));
            check("scroll_led", 32'(LEDR), 32'(led_walk[s]));
        end

        // game over: static digits, LED flash, load on a wrap edge
        mode = 2'd3;
        cyc();
        cyc();
        check("go_hex", 32'(HEX_OUT), 32'(pat1234));
        check("go_led_on", 32'(LEDR), 32'h3FF);
        cyc(); cyc(); cyc();
        check("go_tick", 32'(step_tick), 32'h1);
        cyc();
        check("go_led_off", 32'(LEDR), 32'h0);
        cyc(); cyc();
        load = 1'b1;
        cyc();
        check("go_load_tick", 32'(step_tick), 32'h0);
        load = 1'b0;
        cyc();
        check("go_phase0", 32'(LEDR), 32'h3FF);
        cyc(); cyc(); cyc();
        check("go_rewrap", 32'(step_tick), 32'h1);

        // reset in the middle of a scroll at offset 2
        mode = 2'd2;
        cyc();
        for (int i = 0; i < 7; i++) cyc();
        check("mid_d0", 32'(HEX_OUT[6:0]), 32'h24);
        check("mid_led", 32'(LEDR), 32'h004);
        reset = 1'b1;
        cyc();
        check("mid_rst_hex", 32'(HEX_OUT), 32'h0FFFFFFF);
        check("mid_rst_led", 32'(LEDR), 32'h0);
        reset = 1'b0;
        cyc();
        cyc();
        check("post_rst_hex", 32'(HEX_OUT), 32'h0FFFFFFF);
        check("post_rst_led", 32'(LEDR), 32'h001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
